cic_int_chain: RTL
==================

# cic_int_chain

Parametrised, time-multiplexed CIC integrator section for the decimation filter datapath. It sign-extends each input sample to the full growth width and runs it through NINT cascaded, pipelined integrators. Each of NCH interleaved channels keeps independent state. A per-channel decimation phase counter flags every R-th output sample. The block feeds the decimator/comb section directly.

## Interface
- Win, 16: input sample width (signed).
- Wg, 22: bit growth; internal and output width W = Win+Wg.
- NINT, 3: number of cascaded integrator stages (≥1).
- NCH, 1: number of interleaved channels (≥1); CHW = max(1, clog2(NCH)).
- R, 8: decimation ratio for dec_out (≥1).

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- clr  in  1  synchronous clear of all integrator state and phase counters; pipeline contents discarded.
- data_in  in  Win  signed input sample.
- ch_in  in  CHW  channel index of data_in; values ≥ NCH are ignored (sample dropped).
- val_in  in  1  data_in/ch_in valid this cycle.
- data_out  out  W  signed integrator-chain output.
- ch_out  out  CHW  channel of data_out.
- val_out  out  1  single-cycle pulse per output sample.
- dec_out  out  1  with val_out: this sample is the one the decimator keeps.

## Operation
- Stage k, for channel c: s_k[c] ← s_k[c] + x_k, where x_1 = sext(data_in) and x_k = output of stage k−1. Output of stage k is the updated s_k[c].
- All arithmetic is W-bit two's complement with wrap-around; no saturation. Modular overflow is intended, as the comb section cancels it.
- Each stage has NCH state words plus one pipeline register carrying value, channel and valid. A stage does read-modify-write of s_k[ch] in its own cycle, so back-to-back samples of the same channel need no bubble.
- Phase counter ph[c] counts 0..R−1. It increments when a channel-c sample leaves the last stage, wrapping R−1→0. dec_out=1 when ph[c]==R−1 before the increment. With R=1, dec_out=1 on every val_out.
- Invalid cycles (val_in=0) leave all state unchanged and propagate a bubble.
- clr=1: all s_k, ph and pipeline valids go to 0 next cycle. A val_in in the same cycle is dropped (clr wins).
- rst: same as clr, and additionally data_out=0, ch_out=0, val_out=0, dec_out=0. Reset mid-stream discards all in-flight samples.
- data_out and ch_out hold their last value when val_out=0.

## Timing
- Latency: NINT cycles from the val_in edge to the val_out pulse. Throughput is 1 sample/cycle, any channel order.
- First valid output after rst/clr: the first accepted sample, NINT cycles later.
- clr/rst assertion takes effect on the next edge. The first sample accepted is the one in the cycle after deassertion.
- dec_out is only ever 1 when val_out is 1.

## Structure
- Package cic_pkg:
  - function cic_w(Win, Wg) and chw(NCH).
  - typedef of the per-stage pipeline bundle: value, channel, valid.
- Sub-module cic_int_stage: one integrator stage with an NCH-deep state array, clr/rst handling and its pipeline register. cic_int_chain instantiates NINT of them in a generate loop, and adds input sign-extension and the phase counter array.

## Test plan
- NINT=1, NCH=1: data_in=1 on 4 consecutive cycles → data_out 1,2,3,4, each 1 cycle after its input; val_out pulses 4×.
- NINT=3, NCH=1, impulse data_in=1 then zeros → outputs 1,3,6,10,15 (triangular numbers), first at latency 3.
- Wrap: Win=4, Wg=2, NINT=1, constant input 7 → 7,14,21,28,−29 (wraps at 6 bits).
- NCH=2, NINT=1, interleave ch0=+1 and ch1=−2 every cycle → ch0 outputs 1,2,3, ch1 outputs −2,−4,−6; ch_out matches.
- R=4, NCH=2, interleaved: dec_out high on the 4th, 8th, … output of each channel independently. Gaps in val_in do not advance the phase.
- clr asserted mid-stream with val_in=1 → that sample is dropped, no val_out for in-flight samples. Restart with input 1 gives 1 again. rst mid-stream gives all outputs 0 next cycle.

Source files
------------

// File: rtl/cic_pkg.sv
// Shared sizing helpers and the inter-stage pipeline bundle for the CIC integrator chain.
// The bundle carries the widest supported value/channel; stages use only the low bits they need.
package cic_pkg;

    localparam int CIC_W_MAX   = 64;
    localparam int CIC_CHW_MAX = 8;

    function automatic int cic_w(input int win, input int wg);
        return win + wg;
    endfunction

    function automatic int chw(input int nch);
        return (nch <= 1) ? 1 : $clog2(nch);
    endfunction

    typedef struct packed {
        logic [CIC_W_MAX-1:0]   value;
        logic [CIC_CHW_MAX-1:0] ch;
        logic                   valid;
    } cic_bundle_t;

endpackage

// File: rtl/cic_int_chain_if.sv
// Sample-in / sample-out bus of the integrator chain.
// A sample is transferred on every rising edge where val_in (resp. val_out) is 1; there is no back-pressure.
interface cic_int_chain_if
    import cic_pkg::*;
#(
    parameter int Win = 16,
    parameter int Wg  = 22,
    parameter int NCH = 1
);

    localparam int W   = cic_w(Win, Wg);
    localparam int CHW = chw(NCH);

    logic signed [Win-1:0] data_in;
    logic [CHW-1:0]        ch_in;
    logic                  val_in;
    logic signed [W-1:0]   data_out;
    logic [CHW-1:0]        ch_out;
    logic                  val_out;
    logic                  dec_out;

    modport master (
        output data_in, ch_in, val_in,
        input  data_out, ch_out, val_out, dec_out
    );

    modport slave (
        input  data_in, ch_in, val_in,
        output data_out, ch_out, val_out, dec_out
    );

endinterface

// File: rtl/cic_int_stage.sv
// One time-multiplexed integrator stage: per-channel accumulator plus an output pipeline register.
// Read-modify-write of the channel's accumulator completes in one cycle, so same-channel samples may be back-to-back.
module cic_int_stage
    import cic_pkg::*;
#(
    parameter int W   = 38,
    parameter int NCH = 1,
    parameter int CHW = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  cic_bundle_t in_b,
    output cic_bundle_t out_b
);

    logic [W-1:0]   acc [NCH];
    logic [W-1:0]   cur;
    logic [W-1:0]   sum;
    logic [CHW-1:0] ch;
    logic           unused_in;

    assign ch        = in_b.ch[CHW-1:0];
    assign unused_in = ^in_b;

    always_comb begin
        cur = '0;
        for (int c = 0; c < NCH; c++) begin
            if (ch == CHW'(c)) cur = acc[c];
        end
    end

    // Modular wrap-around is intended; the comb section cancels it.
    assign sum = cur + in_b.value[W-1:0];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int c = 0; c < NCH; c++) acc[c] <= '0;
            out_b.valid <= 1'b0;
            if (rst) begin
                out_b.value <= '0;
                out_b.ch    <= '0;
            end
        end else begin
            out_b.valid <= in_b.valid;
            if (in_b.valid) begin
                for (int c = 0; c < NCH; c++) begin
                    if (ch == CHW'(c)) acc[c] <= sum;
                end
                out_b.value <= CIC_W_MAX'(signed'(sum));
                out_b.ch    <= CIC_CHW_MAX'(ch);
            end
        end
    end

endmodule

// File: rtl/cic_int_chain.sv
// Time-multiplexed CIC integrator chain: sign extension, NINT pipelined integrator stages,
// and a per-channel decimation phase counter that marks every R-th output of each channel.
module cic_int_chain
    import cic_pkg::*;
#(
    parameter int Win  = 16,
    parameter int Wg   = 22,
    parameter int NINT = 3,
    parameter int NCH  = 1,
    parameter int R    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    cic_int_chain_if.slave  bus
);

    localparam int W   = cic_w(Win, Wg);
    localparam int CHW = chw(NCH);
    localparam int PHW = (R > 1) ? $clog2(R) : 1;

    cic_bundle_t    pipe [NINT+1];
    cic_bundle_t    head;
    cic_bundle_t    last;
    logic           in_ok;
    logic [CHW-1:0] last_ch;
    logic [PHW-1:0] ph [NCH];
    logic [PHW-1:0] ph_cur;
    logic           at_end;
    logic           unused_last;

    // Out-of-range channels are dropped here; clr also wins over a same-cycle sample.
    assign in_ok = bus.val_in && (int'(bus.ch_in) < NCH);

    always_comb begin
        head       = '0;
        head.value = CIC_W_MAX'(bus.data_in);
        head.ch    = CIC_CHW_MAX'(bus.ch_in);
        head.valid = in_ok && !clr;
    end

    assign pipe[0] = head;

    for (genvar k = 0; k < NINT; k++) begin : g_stage
        cic_int_stage #(
            .W   (W),
            .NCH (NCH),
            .CHW (CHW)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .clr   (clr),
            .in_b  (pipe[k]),
            .out_b (pipe[k+1])
        );
    end

    assign last        = pipe[NINT];
    assign last_ch     = last.ch[CHW-1:0];
    assign unused_last = ^{last.value, last.ch};

    always_comb begin
        ph_cur = '0;
        for (int c = 0; c < NCH; c++) begin
            if (last_ch == CHW'(c)) ph_cur = ph[c];
        end
    end

    assign at_end = (ph_cur == PHW'(R - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int c = 0; c < NCH; c++) ph[c] <= '0;
        end else if (last.valid) begin
            for (int c = 0; c < NCH; c++) begin
                if (last_ch == CHW'(c)) ph[c] <= at_end ? '0 : ph_cur + 1'b1;
            end
        end
    end

    assign bus.data_out = last.value[W-1:0];
    assign bus.ch_out   = last_ch;
    assign bus.val_out  = last.valid;
    assign bus.dec_out  = last.valid && at_end;

endmodule
